// File: rtl/sram_mirror_ctrl.sv
// Sequencer from the asynchronous MCU SRAM bus to two external 16-bit SRAMs.
// Each MCU chip-select period becomes one timed access, optionally mirrored with a read compare.
module sram_mirror_ctrl #(
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned ADDR_W   = 21,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mcu_cs_n,
  input  logic              mcu_we_n,
  input  logic              mcu_oe_n,
  input  logic              mcu_lb_n,
  input  logic              mcu_ub_n,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [DATA_W-1:0] mcu_wdata,
  output logic [DATA_W-1:0] mcu_rdata,
  output logic              mcu_rdata_oe,
  input  logic [1:0]        ecc_sel,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [1:0]        sram_cs_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wdata_oe,
  input  logic [DATA_W-1:0] sram_rdata_up,
  input  logic [DATA_W-1:0] sram_rdata_down,
  output logic              busy,
  output logic              mismatch,
  output logic [7:0]        err_count
);

  localparam int unsigned LoW      = DATA_W / 2;
  localparam int unsigned HiW      = DATA_W - LoW;
  localparam logic [3:0]  WaitLast = 4'(WAIT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StCapture, StHold} state_e;

  state_e state_q, state_d;
  logic [1:0] cs_sync_q, we_sync_q, oe_sync_q;
  logic cs_s, we_s, oe_s;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, cap_up_q, cap_up_d, cap_dn_q, cap_dn_d;
  logic              lb_q, lb_d, ub_q, ub_d, wr_q, wr_d, rd_q, rd_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [ADDR_W-1:0] sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_d, mcu_rdata_d;
  logic [1:0]        sram_cs_n_d, chip_en;
  logic sram_we_n_d, sram_oe_n_d, sram_lb_n_d, sram_ub_n_d, sram_wdata_oe_d;
  logic mcu_rdata_oe_d, busy_d, mismatch_d, active, mirror, miscmp;
  logic [DATA_W-1:0] lane_mask;
  logic [7:0]        err_count_d;

  assign cs_s = cs_sync_q[1];
  assign we_s = we_sync_q[1];
  assign oe_s = oe_sync_q[1];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lb_d     = lb_q;
    ub_d     = ub_q;
    sel_d    = sel_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    cap_up_d = cap_up_q;
    cap_dn_d = cap_dn_q;
    unique case (state_q)
      StIdle: begin
        if (!cs_s) begin
          addr_d  = mcu_addr;
          wdata_d = mcu_wdata;
          lb_d    = mcu_lb_n;
          ub_d    = mcu_ub_n;
          sel_d   = ecc_sel;
          wr_d    = !we_s;
          rd_d    = we_s && !oe_s;
          state_d = (!we_s || !oe_s) ? StSetup : StHold;
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = WaitLast;
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StCapture;
          if (rd_q) begin
            cap_up_d = sram_rdata_up;
            cap_dn_d = sram_rdata_down;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCapture: state_d = StHold;
      StHold:    if (cs_s) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are registered copies of what the next state demands, so they track state_q exactly.
  always_comb begin
    active  = (state_d == StSetup) || (state_d == StAccess) || (state_d == StCapture);
    chip_en = {sel_d != 2'b11, sel_d != 2'b00};
    sram_cs_n_d     = active ? ~chip_en : 2'b11;
    sram_addr_d     = active ? addr_d : sram_addr;
    sram_wdata_d    = (active && wr_d) ? wdata_d : sram_wdata;
    sram_wdata_oe_d = active && wr_d;
    sram_we_n_d     = !((state_d == StAccess) && wr_d);
    sram_oe_n_d     = !((state_d == StAccess) && rd_d);
    sram_lb_n_d     = (state_d == StAccess) ? lb_d : 1'b1;
    sram_ub_n_d     = (state_d == StAccess) ? ub_d : 1'b1;
    busy_d          = (state_d != StIdle);
    mcu_rdata_oe_d  = (state_d == StHold) && rd_d && !oe_s;

    lane_mask = {{HiW{~ub_q}}, {LoW{~lb_q}}};
    mirror    = (sel_q == 2'b01) || (sel_q == 2'b10);
    miscmp    = mirror && rd_q && (((cap_up_q ^ cap_dn_q) & lane_mask) != '0);

    mcu_rdata_d = mcu_rdata;
    mismatch_d  = mismatch;
    err_count_d = err_count;
    if (state_q == StCapture) begin
      if (rd_q) mcu_rdata_d = sel_q[1] ? cap_dn_q : cap_up_q;
      mismatch_d = miscmp;
      if (miscmp && (err_count != 8'hFF)) err_count_d = err_count + 8'd1;
    end
    if (err_clr) err_count_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q     <= 2'b11;
      we_sync_q     <= 2'b11;
      oe_sync_q     <= 2'b11;
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      lb_q          <= 1'b1;
      ub_q          <= 1'b1;
      sel_q         <= 2'b00;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      cnt_q         <= 4'd0;
      cap_up_q      <= '0;
      cap_dn_q      <= '0;
      sram_addr     <= '0;
      sram_cs_n     <= 2'b11;
      sram_we_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_lb_n     <= 1'b1;
      sram_ub_n     <= 1'b1;
      sram_wdata    <= '0;
      sram_wdata_oe <= 1'b0;
      mcu_rdata     <= '0;
      mcu_rdata_oe  <= 1'b0;
      busy          <= 1'b0;
      mismatch      <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      cs_sync_q     <= {cs_sync_q[0], mcu_cs_n};
      we_sync_q     <= {we_sync_q[0], mcu_we_n};
      oe_sync_q     <= {oe_sync_q[0], mcu_oe_n};
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      lb_q          <= lb_d;
      ub_q          <= ub_d;
      sel_q         <= sel_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      cap_up_q      <= cap_up_d;
      cap_dn_q      <= cap_dn_d;
      sram_addr     <= sram_addr_d;
      sram_cs_n     <= sram_cs_n_d;
      sram_we_n     <= sram_we_n_d;
      sram_oe_n     <= sram_oe_n_d;
      sram_lb_n     <= sram_lb_n_d;
      sram_ub_n     <= sram_ub_n_d;
      sram_wdata    <= sram_wdata_d;
      sram_wdata_oe <= sram_wdata_oe_d;
      mcu_rdata     <= mcu_rdata_d;
      mcu_rdata_oe  <= mcu_rdata_oe_d;
      busy          <= busy_d;
      mismatch      <= mismatch_d;
      err_count     <= err_count_d;
    end
  end

endmodule

// File: tb/tb_sram_mirror_ctrl.sv
// Scoreboard bench for sram_mirror_ctrl: stimulus queues expected access results,
// a monitor watches the SRAM bus and checks each completed access when busy drops.
module tb_sram_mirror_ctrl;

  localparam int unsigned WAIT_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mcu_cs_n = 1'b1, mcu_we_n = 1'b1, mcu_oe_n = 1'b1;
  logic        mcu_lb_n = 1'b1, mcu_ub_n = 1'b1;
  logic [20:0] mcu_addr = '0;
  logic [15:0] mcu_wdata = '0;
  logic [15:0] mcu_rdata;
  logic        mcu_rdata_oe;
  logic [1:0]  ecc_sel = 2'b00;
  logic        err_clr = 1'b0;
  logic [20:0] sram_addr;
  logic [1:0]  sram_cs_n;
  logic        sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n;
  logic [15:0] sram_wdata;
  logic        sram_wdata_oe;
  logic [15:0] sram_rdata_up = '0, sram_rdata_down = '0;
  logic        busy, mismatch;
  logic [7:0]  err_count;

  sram_mirror_ctrl #(.WAIT_CYC(WAIT_CYC), .ADDR_W(21), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mcu_cs_n(mcu_cs_n), .mcu_we_n(mcu_we_n), .mcu_oe_n(mcu_oe_n),
    .mcu_lb_n(mcu_lb_n), .mcu_ub_n(mcu_ub_n),
    .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .mcu_rdata(mcu_rdata), .mcu_rdata_oe(mcu_rdata_oe),
    .ecc_sel(ecc_sel), .err_clr(err_clr),
    .sram_addr(sram_addr), .sram_cs_n(sram_cs_n),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
    .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
    .sram_rdata_up(sram_rdata_up), .sram_rdata_down(sram_rdata_down),
    .busy(busy), .mismatch(mismatch), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        mm;
    logic [7:0]  err;
    logic [1:0]  cs;
    int          we_cyc;
    int          oe_cyc;
    int          wdoe_cyc;
    logic [15:0] wdata;
    logic [20:0] addr;
    logic        rdoe;
    logic [1:0]  lbub;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] rdata, input logic mm, input logic [7:0] err,
                              input logic [1:0] cs, input int we_cyc, input int oe_cyc,
                              input int wdoe_cyc, input logic [15:0] wdata,
                              input logic [20:0] addr, input logic rdoe, input logic [1:0] lbub);
    exp_t e;
    e.rdata = rdata; e.mm = mm; e.err = err; e.cs = cs; e.we_cyc = we_cyc; e.oe_cyc = oe_cyc;
    e.wdoe_cyc = wdoe_cyc; e.wdata = wdata; e.addr = addr; e.rdoe = rdoe; e.lbub = lbub;
    return e;
  endfunction

  // Monitor: accumulate per-access bus activity, check it when busy falls.
  logic [1:0]  cs_acc;
  int          we_cnt, oe_cnt, wdoe_cnt;
  logic [15:0] wd_seen;
  logic        wd_changed, rdoe_seen, busy_prev;
  logic [20:0] addr_seen;
  logic [1:0]  lbub_seen;

  task automatic mon_clear();
    cs_acc = 2'b11; we_cnt = 0; oe_cnt = 0; wdoe_cnt = 0; wd_seen = '0; wd_changed = 1'b0;
    rdoe_seen = 1'b0; addr_seen = '0; lbub_seen = 2'b11;
  endtask

  initial begin
    exp_t e;
    mon_clear();
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_clear();
        busy_prev = 1'b0;
      end else begin
        cs_acc = cs_acc & sram_cs_n;
        if (sram_cs_n != 2'b11) addr_seen = sram_addr;
        if (!sram_we_n) begin we_cnt++; lbub_seen = {sram_ub_n, sram_lb_n}; end
        if (!sram_oe_n) begin oe_cnt++; lbub_seen = {sram_ub_n, sram_lb_n}; end
        if (sram_wdata_oe) begin
          if (wdoe_cnt > 0 && sram_wdata != wd_seen) wd_changed = 1'b1;
          wd_seen = sram_wdata;
          wdoe_cnt++;
        end
        rdoe_seen = rdoe_seen | mcu_rdata_oe;
        if (busy_prev && !busy) begin
          if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_completion: got a completed access, expected none");
          end else begin
            e = sb_q.pop_front();
            chk("mcu_rdata", 32'(mcu_rdata), 32'(e.rdata));
            chk("mismatch", 32'(mismatch), 32'(e.mm));
            chk("err_count", 32'(err_count), 32'(e.err));
            chk("cs_n_active", 32'(cs_acc), 32'(e.cs));
            chk("we_low_cycles", we_cnt, e.we_cyc);
            chk("oe_low_cycles", oe_cnt, e.oe_cyc);
            chk("wdata_oe_cycles", wdoe_cnt, e.wdoe_cyc);
            chk("rdata_oe_seen", 32'(rdoe_seen), 32'(e.rdoe));
            if (e.wdoe_cyc > 0) begin
              chk("sram_wdata", 32'(wd_seen), 32'(e.wdata));
              chk("sram_wdata_stable", 32'(wd_changed), 32'd0);
            end
            if (e.cs != 2'b11) chk("sram_addr", 32'(addr_seen), 32'(e.addr));
            if (e.we_cyc + e.oe_cyc > 0) chk("byte_lanes", 32'(lbub_seen), 32'(e.lbub));
          end
          mon_clear();
        end
        busy_prev = busy;
      end
    end
  end

  task automatic do_access(input logic we_n, input logic oe_n, input logic lb_n,
                           input logic ub_n, input logic [1:0] sel, input logic [20:0] addr,
                           input logic [15:0] wd, input logic [15:0] up, input logic [15:0] dn,
                           input exp_t e);
    int i;
    sb_q.push_back(e);
    @(posedge clk); #2;
    mcu_we_n = we_n; mcu_oe_n = oe_n; mcu_lb_n = lb_n; mcu_ub_n = ub_n;
    ecc_sel = sel; mcu_addr = addr; mcu_wdata = wd;
    sram_rdata_up = up; sram_rdata_down = dn;
    mcu_cs_n = 1'b0;
    repeat (WAIT_CYC + 10) @(posedge clk);
    #2;
    mcu_cs_n = 1'b1; mcu_we_n = 1'b1; mcu_oe_n = 1'b1;
    i = 0;
    @(negedge clk);
    while (busy && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (busy) begin
      n_fail++;
      $display("FAIL busy_timeout: busy still 1 after 40 cycles, expected 0");
    end
    repeat (2) @(negedge clk);
    chk("access_completed", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    logic [7:0] m_err;
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m_err;
    int i;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_cs_n", 32'(sram_cs_n), 32'h3);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'h1);
    chk("rst_lbub_n", 32'({sram_ub_n, sram_lb_n}), 32'h3);
    chk("rst_oes", 32'({sram_wdata_oe, mcu_rdata_oe}), 32'h0);
    chk("rst_data", 32'({sram_addr, 11'h0} | 32'(sram_wdata) | 32'(mcu_rdata)), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mismatch", 32'(mismatch), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);

    // Mirrored write, then mirrored reads with and without a compare miss.
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 21'h12345, 16'hA5C3, 16'h0, 16'h0,
              mk(16'h0000, 0, 8'd0, 2'b00, 2, 0, 4, 16'hA5C3, 21'h12345, 0, 2'b00));
    do_access(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 21'h00010, 16'h0, 16'h1357, 16'h1357,
              mk(16'h1357, 0, 8'd0, 2'b00, 0, 2, 0, 16'h0, 21'h00010, 1, 2'b00));
    do_access(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 21'h00020, 16'h0, 16'h00FF, 16'h01FF,
              mk(16'h01FF, 1, 8'd1, 2'b00, 0, 2, 0, 16'h0, 21'h00020, 1, 2'b00));
    do_access(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 21'h00020, 16'h0, 16'h00FF, 16'h01FF,
              mk(16'h01FF, 0, 8'd1, 2'b00, 0, 2, 0, 16'h0, 21'h00020, 1, 2'b10));
    // Single-chip writes and a strobe-less chip-select cycle.
    do_access(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 21'h00100, 16'h1111, 16'h0, 16'h0,
              mk(16'h01FF, 0, 8'd1, 2'b01, 2, 0, 4, 16'h1111, 21'h00100, 0, 2'b01));
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 21'h1FFFFF, 16'h2222, 16'h0, 16'h0,
              mk(16'h01FF, 0, 8'd1, 2'b10, 2, 0, 4, 16'h2222, 21'h1FFFFF, 0, 2'b10));
    do_access(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 21'h00200, 16'h3333, 16'h0, 16'h0,
              mk(16'h01FF, 0, 8'd1, 2'b11, 0, 0, 0, 16'h0, 21'h0, 0, 2'b00));

    // Saturation of the error counter.
    m_err = 8'd1;
    for (i = 0; i < 256; i++) begin
      m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
      do_access(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 21'(i), 16'h0, 16'h0001, 16'h0002,
                mk(16'h0001, 1, m_err, 2'b00, 0, 2, 0, 16'h0, 21'(i), 1, 2'b00));
    end
    // Clear held across a mismatching read beats the increment.
    @(posedge clk); #2 err_clr = 1'b1;
    do_access(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 21'h00300, 16'h0, 16'h0001, 16'h0002,
              mk(16'h0001, 1, 8'd0, 2'b00, 0, 2, 0, 16'h0, 21'h00300, 1, 2'b00));
    @(posedge clk); #2 err_clr = 1'b0;
    do_access(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 21'h00301, 16'h0, 16'h0001, 16'h0002,
              mk(16'h0002, 1, 8'd1, 2'b00, 0, 2, 0, 16'h0, 21'h00301, 1, 2'b00));

    // Reset during the strobe of a write.
    @(posedge clk); #2;
    mcu_we_n = 1'b0; ecc_sel = 2'b01; mcu_addr = 21'h00400; mcu_wdata = 16'hDEAD;
    mcu_cs_n = 1'b0;
    i = 0;
    @(negedge clk);
    while (sram_we_n && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("abort_strobe_seen", 32'(sram_we_n), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'h1);
    chk("abort_cs_n", 32'(sram_cs_n), 32'h3);
    chk("abort_wdata_oe", 32'(sram_wdata_oe), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    mcu_cs_n = 1'b1; mcu_we_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 21'h00ABC, 16'h5A5A, 16'h0, 16'h0,
              mk(16'h0000, 0, 8'd0, 2'b00, 2, 0, 4, 16'h5A5A, 21'h00ABC, 0, 2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_mirror_ctrl.md
# sram_mirror_ctrl

Synchronous sequencer between the MCU asynchronous SRAM-style bus and the two external SRAM chips, the upper and lower 16-bit devices. It turns each MCU chip-select period into exactly one timed SRAM access. The ecc_sel setting steers each access to a single chip or mirrors it to both. Mirrored reads are compared, and mismatches are flagged and counted. It replaces the direct MCU-to-SRAM strobe wiring inside the FPGA top level.

## Interface
- WAIT_CYC, 2: SRAM strobe width in clk cycles; legal range 1–15.
- ADDR_W, 21: address width.
- DATA_W, 16: data width per chip.
- clk  in  1  system clock; this is the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- mcu_cs_n, mcu_we_n, mcu_oe_n  in  1 each  MCU strobes, asynchronous to clk; each passes through a 2-flop synchronizer.
- mcu_lb_n, mcu_ub_n  in  1 each  MCU byte enables, active-low.
- mcu_addr  in  ADDR_W  MCU address; stable while mcu_cs_n is low.
- mcu_wdata  in  DATA_W  MCU write data.
- mcu_rdata  out  DATA_W  read data returned to the MCU.
- mcu_rdata_oe  out  1  MCU data-bus output enable.
- ecc_sel  in  2  access mode; sampled at access start.
- err_clr  in  1  synchronous clear of err_count.
- sram_addr  out  ADDR_W  SRAM address.
- sram_cs_n  out  2  chip selects; [1] = up chip, [0] = down chip.
- sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n  out  1 each  SRAM control strobes, shared by both chips.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_wdata_oe  out  1  SRAM data-bus output enable.
- sram_rdata_up, sram_rdata_down  in  DATA_W each  read data from the up and down chips.
- busy  out  1  high whenever the FSM is not in IDLE.
- mismatch  out  1  result of the last mirrored read compare.
- err_count  out  8  count of mismatched reads; saturates at 255.

## Operation
- Reset values:
  - sram_cs_n = 2'b11; sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n = 1.
  - sram_wdata_oe = 0 and mcu_rdata_oe = 0.
  - sram_addr, sram_wdata, mcu_rdata = 0.
  - busy = 0, mismatch = 0, err_count = 0.
  - FSM = IDLE; synchronizer flops reset to 1.
- All outputs are registered.
- FSM states: IDLE → SETUP → ACCESS → CAPTURE → HOLD → IDLE.
- IDLE:
  - Leaves when cs_s (the synchronized mcu_cs_n) is low.
  - On that edge: latch mcu_addr, mcu_wdata, the byte enables and ecc_sel.
  - Latch the access direction: write if we_s is low; otherwise read if oe_s is low.
  - If neither we_s nor oe_s is low, go directly to HOLD. No SRAM strobe toggles.
- SETUP (1 cycle): sram_addr is valid and the selected sram_cs_n bits are low. For a write, sram_wdata and sram_wdata_oe are driven.
- ACCESS (WAIT_CYC cycles): sram_we_n (write) or sram_oe_n (read) is low, together with the latched lb/ub values.
- Leaving ACCESS:
  - The strobe returns high.
  - For a read, sram_rdata_up and sram_rdata_down are registered on this edge.
- CAPTURE (1 cycle):
  - Chip selects and write data are still held.
  - On exit: sram_cs_n = 11, sram_wdata_oe = 0; mcu_rdata, mismatch and err_count are updated.
- HOLD:
  - Waits for cs_s high, then returns to IDLE.
  - For reads, mcu_rdata_oe = ~oe_s.
  - mcu_rdata_oe = 0 on entry to IDLE.
- Each low period of cs_s produces exactly one access. There is no back-to-back access without a deassertion.
- ecc_sel modes:
  - 00: up chip only; read returns up data.
  - 01: mirror; write both chips; read both and return up data.
  - 10: mirror; return down data.
  - 11: down chip only.
- Mirror compare covers only the enabled byte lanes. Disabled lanes are masked to 0 before the compare.
- Single-chip reads and all writes set mismatch = 0.
- Mismatch set → err_count increments, saturating at 255.
- err_clr wins over a simultaneous increment.

## Timing
- Latency from an mcu_cs_n fall to FSM start is 2–3 clk (synchronizer plus edge alignment).
- Counting from the IDLE exit edge E0:
  - Strobe asserted after E1.
  - Strobe deasserted after E1+WAIT_CYC.
  - mcu_rdata valid after E2+WAIT_CYC.
- Write pulse = WAIT_CYC cycles. Address and CS setup before the strobe = 1 cycle. CS and data hold after the strobe = 1 cycle.
- If cs_s rises during SETUP, ACCESS or CAPTURE, the access still completes in full. HOLD then exits on its first cycle.
- Strobe changes during an access are ignored; direction is fixed at E0.
- ecc_sel changes during an access are ignored; the latched mode applies.
- rst_n low mid-access: all strobes go inactive and the output enables go low immediately (asynchronous), with no partial-write recovery.

## Test plan
- Write, ecc_sel = 01, addr 0x12345, data 0xA5C3, WAIT_CYC = 2 → both sram_cs_n low, sram_we_n low for exactly 2 cycles, sram_wdata = 0xA5C3 from SETUP through CAPTURE.
- Read, ecc_sel = 01, up = down = 0x1357 → mcu_rdata = 0x1357, mismatch = 0, err_count unchanged.
- Read, ecc_sel = 10, up = 0x00FF, down = 0x01FF, lb_n = 0, ub_n = 0 → mcu_rdata = 0x01FF, mismatch = 1, err_count +1. Repeat with ub_n = 1 → mismatch = 0.
- 256 mismatched reads, then err_clr asserted on the same cycle as a mismatch → err_count stays at 255 through the reads, then reads 0.
- ecc_sel = 00 and ecc_sel = 11 writes → only sram_cs_n[1], or only sram_cs_n[0], goes low. Strobe-less CS cycle → no strobe toggles, busy returns to 0.
- rst_n asserted during ACCESS of a write → sram_we_n = 1, sram_cs_n = 11 and sram_wdata_oe = 0 immediately. After release, the next CS cycle completes normally.
